// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the two-requester data-memory arbiter.
package dmem_arbiter_pkg;

   localparam int DW_DEF       = 32;
   localparam int IDX_W_DEF    = 5;
   localparam int MAX_LOCK_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOCK0 = 2'd1,
      ST_LOCK1 = 2'd2
   } state_e;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   // Misaligned word access or any address bit above the word index set.
   function automatic logic addr_err(input logic [31:0] a, input int idx_w);
      return (a[1:0] != 2'b00) || ((a >> (idx_w + 2)) != 32'd0);
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if #(parameter int DW = 32);

   logic          r0_req, r0_we, r0_lock;
   logic [31:0]   r0_addr;
   logic [DW-1:0] r0_wdata;
   logic          r0_gnt, r0_rvalid, r0_err;
   logic [DW-1:0] r0_rdata;

   logic          r1_req, r1_we, r1_lock;
   logic [31:0]   r1_addr;
   logic [DW-1:0] r1_wdata;
   logic          r1_gnt, r1_rvalid, r1_err;
   logic [DW-1:0] r1_rdata;

   logic          mem_we;
   logic [31:0]   mem_addr;
   logic [DW-1:0] mem_datain;
   logic [DW-1:0] mem_dataout;

   modport slave (
      input  r0_req, r0_we, r0_lock, r0_addr, r0_wdata,
      output r0_gnt, r0_rvalid, r0_err, r0_rdata,
      input  r1_req, r1_we, r1_lock, r1_addr, r1_wdata,
      output r1_gnt, r1_rvalid, r1_err, r1_rdata,
      output mem_we, mem_addr, mem_datain,
      input  mem_dataout
   );

   modport master (
      output r0_req, r0_we, r0_lock, r0_addr, r0_wdata,
      input  r0_gnt, r0_rvalid, r0_err, r0_rdata,
      output r1_req, r1_we, r1_lock, r1_addr, r1_wdata,
      input  r1_gnt, r1_rvalid, r1_err, r1_rdata,
      input  mem_we, mem_addr, mem_datain,
      output mem_dataout
   );

endinterface

// File: rtl/dmem_arb_pick.sv
// Round-robin pick between two requesters; on contention the one not granted last wins.
module dmem_arb_pick (
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic [1:0] o_gnt
);

   always_comb begin
      o_gnt = i_req;
      if (i_req == 2'b11) o_gnt = i_last ? 2'b01 : 2'b10;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between CPU (r0) and DMA (r1) with
// round-robin arbitration, a bounded ownership lock and registered responses.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int DW       = DW_DEF,
   parameter int IDX_W    = IDX_W_DEF,
   parameter int MAX_LOCK = MAX_LOCK_DEF
) (
   input  logic           clk,
   input  logic           reset,
   dmem_arbiter_if.slave  bus
);

   localparam int            CW       = $clog2(MAX_LOCK + 1);
   localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);

   logic [1:0]            w_req, w_we, w_lock, w_err, w_gnt, w_pick_req, w_pick_gnt;
   logic [1:0][31:0]      w_addr;
   logic [1:0][DW-1:0]    w_wdata;
   logic                  w_own, w_locked;

   state_e                r_state, w_state_nx;
   logic                  r_last, w_last_nx;
   logic [CW-1:0]         r_cnt, w_cnt_nx;

   logic [1:0]            r_rvalid, r_err;
   logic [1:0][DW-1:0]    r_rdata;

   assign w_req   = {bus.r1_req,   bus.r0_req};
   assign w_we    = {bus.r1_we,    bus.r0_we};
   assign w_lock  = {bus.r1_lock,  bus.r0_lock};
   assign w_addr  = {bus.r1_addr,  bus.r0_addr};
   assign w_wdata = {bus.r1_wdata, bus.r0_wdata};
   assign w_err   = {addr_err(bus.r1_addr, IDX_W), addr_err(bus.r0_addr, IDX_W)};

   assign w_own    = (r_state == ST_LOCK1);
   assign w_locked = (r_state != ST_IDLE);
   // When the owner has dropped its request, only the other side competes.
   assign w_pick_req = w_locked ? (w_req & ~(2'b01 << w_own)) : w_req;

   dmem_arb_pick u_pick (
      .i_req  (w_pick_req),
      .i_last (r_last),
      .o_gnt  (w_pick_gnt)
   );

   always_comb begin
      w_gnt      = '0;
      w_state_nx = r_state;
      w_last_nx  = r_last;
      w_cnt_nx   = r_cnt;
      if (!w_locked || !w_req[w_own]) begin
         w_gnt      = w_pick_gnt;
         w_state_nx = ST_IDLE;
         if (w_gnt[0]) begin
            w_last_nx = REQ0;
            if (w_lock[0]) begin
               w_state_nx = ST_LOCK0;
               w_cnt_nx   = CW'(1);
            end
         end else if (w_gnt[1]) begin
            w_last_nx = REQ1;
            if (w_lock[1]) begin
               w_state_nx = ST_LOCK1;
               w_cnt_nx   = CW'(1);
            end
         end
      end else if (r_cnt >= LOCK_MAX && w_req[~w_own]) begin
         // Lock budget spent while the other side waits: release without a grant.
         w_state_nx = ST_IDLE;
         w_last_nx  = w_own;
      end else begin
         w_gnt[w_own] = 1'b1;
         w_last_nx    = w_own;
         if (!w_lock[w_own])      w_state_nx = ST_IDLE;
         else if (r_cnt < LOCK_MAX) w_cnt_nx = r_cnt + CW'(1);
      end
      if (reset) w_gnt = '0;
   end

   assign bus.mem_addr   = w_gnt[0] ? w_addr[0]  : (w_gnt[1] ? w_addr[1]  : '0);
   assign bus.mem_datain = w_gnt[0] ? w_wdata[0] : (w_gnt[1] ? w_wdata[1] : '0);
   assign bus.mem_we     = |(w_gnt & w_we & ~w_err);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_last   <= REQ1;
         r_cnt    <= '0;
         r_rvalid <= '0;
         r_err    <= '0;
         r_rdata  <= '0;
      end else begin
         r_state <= w_state_nx;
         r_last  <= w_last_nx;
         r_cnt   <= w_cnt_nx;
         for (int i = 0; i < 2; i++) begin
            r_rvalid[i] <= w_gnt[i];
            r_err[i]    <= w_gnt[i] & w_err[i];
            r_rdata[i]  <= (w_gnt[i] & ~w_we[i] & ~w_err[i]) ? bus.mem_dataout : '0;
         end
      end
   end

   assign bus.r0_gnt    = w_gnt[0];
   assign bus.r1_gnt    = w_gnt[1];
   assign bus.r0_rvalid = r_rvalid[0];
   assign bus.r1_rvalid = r_rvalid[1];
   assign bus.r0_err    = r_err[0];
   assign bus.r1_err    = r_err[1];
   assign bus.r0_rdata  = r_rdata[0];
   assign bus.r1_rdata  = r_rdata[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 32-word behavioural memory.
module tb_dmem_arbiter;
   import dmem_arbiter_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic mem_init = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   dmem_arbiter_if #(.DW(32)) bus ();

   dmem_arbiter #(.DW(32), .IDX_W(5), .MAX_LOCK(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Memory preloads word i with 0x1000+i.
   logic [31:0] mem [32];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'h1000 + i;
      end else if (bus.mem_we) begin
         mem[bus.mem_addr[6:2]] <= bus.mem_datain;
      end
   end
   assign bus.mem_dataout = mem[bus.mem_addr[6:2]];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drv0(input logic req, input logic we, input logic lock,
                       input logic [31:0] addr, input logic [31:0] wdata);
      bus.r0_req = req; bus.r0_we = we; bus.r0_lock = lock;
      bus.r0_addr = addr; bus.r0_wdata = wdata;
   endtask

   task automatic drv1(input logic req, input logic we, input logic lock,
                       input logic [31:0] addr, input logic [31:0] wdata);
      bus.r1_req = req; bus.r1_we = we; bus.r1_lock = lock;
      bus.r1_addr = addr; bus.r1_wdata = wdata;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected contents during the lock test: word 20 was written with 0xA3.
   function automatic logic [31:0] t3_word(input int idx);
      return (idx == 20) ? 32'h0000_00A3 : 32'(32'h1000 + idx);
   endfunction

   initial begin
      int j;
      drv0(0, 0, 0, 0, 0);
      drv1(0, 0, 0, 0, 0);
      tick();
      mem_init = 1'b0;

      // Reset held with a pending write: dropped.
      drv0(1, 1, 0, 32'h50, 32'hFFFF_FFFF);
      #3;
      check("rst_gnt0", bus.r0_gnt, 0);
      check("rst_mem_we", bus.mem_we, 0);
      tick();
      check("rst_rvalid0", bus.r0_rvalid, 0);
      check("rst_rdata0", bus.r0_rdata, 0);
      check("rst_err0", bus.r0_err, 0);
      check("rst_rvalid1", bus.r1_rvalid, 0);
      reset = 1'b0;

      // Write then read back through r0.
      drv0(1, 1, 0, 32'h50, 32'hA3);
      #3;
      check("t1_gnt0", bus.r0_gnt, 1);
      check("t1_gnt1", bus.r1_gnt, 0);
      check("t1_mem_we", bus.mem_we, 1);
      check("t1_mem_addr", bus.mem_addr, 32'h50);
      check("t1_mem_datain", bus.mem_datain, 32'hA3);
      tick();
      check("t1_wr_rvalid", bus.r0_rvalid, 1);
      check("t1_wr_rdata", bus.r0_rdata, 0);
      check("t1_wr_rvalid1", bus.r1_rvalid, 0);
      drv0(1, 0, 0, 32'h50, 0);
      #3;
      check("t1_rd_gnt0", bus.r0_gnt, 1);
      check("t1_rd_mem_we", bus.mem_we, 0);
      tick();
      check("t1_rd_rvalid", bus.r0_rvalid, 1);
      check("t1_rd_rdata", bus.r0_rdata, 32'hA3);
      check("t1_rd_err", bus.r0_err, 0);

      // Single r1 read; leaves last=r1.
      drv0(0, 0, 0, 0, 0);
      drv1(1, 0, 0, 32'h54, 0);
      #3;
      check("r1_gnt1", bus.r1_gnt, 1);
      tick();
      check("r1_rvalid", bus.r1_rvalid, 1);
      check("r1_rdata", bus.r1_rdata, 32'h1015);

      // Continuous contention: r0 first, then strict alternation.
      drv0(1, 0, 0, 32'h50, 0);
      drv1(1, 0, 0, 32'h54, 0);
      for (int k = 0; k < 6; k++) begin
         #3;
         check("t2_gnt0", bus.r0_gnt, (k % 2) == 0);
         check("t2_gnt1", bus.r1_gnt, (k % 2) == 1);
         tick();
         check("t2_rvalid0", bus.r0_rvalid, (k % 2) == 0);
         check("t2_rvalid1", bus.r1_rvalid, (k % 2) == 1);
         if ((k % 2) == 0) check("t2_rdata0", bus.r0_rdata, 32'hA3);
         else              check("t2_rdata1", bus.r1_rdata, 32'h1015);
      end
      drv0(0, 0, 0, 0, 0);
      drv1(0, 0, 0, 0, 0);

      // Locked r1 burst of 10 reads; r0 waits from cycle 1 and wins at cycle 9.
      j = 0;
      for (int c = 0; c < 12; c++) begin
         drv1(1, 0, (j < 9), 32'(32'h50 + 4 * j), 0);
         drv0((c >= 1 && c <= 9), 0, 0, 32'h58, 0);
         #3;
         check("t3_gnt1", bus.r1_gnt, (c != 8 && c != 9));
         check("t3_gnt0", bus.r0_gnt, (c == 9));
         tick();
         check("t3_rvalid0", bus.r0_rvalid, (c == 9));
         if (c == 9) check("t3_rdata0", bus.r0_rdata, 32'h1016);
         if (c != 8 && c != 9) begin
            check("t3_rvalid1", bus.r1_rvalid, 1);
            check("t3_rdata1", bus.r1_rdata, t3_word(20 + j));
            j++;
         end else begin
            check("t3_rvalid1_idle", bus.r1_rvalid, 0);
         end
      end
      drv0(0, 0, 0, 0, 0);
      drv1(0, 0, 0, 0, 0);

      // Error accesses: misaligned write, out-of-range write, misaligned read.
      drv0(1, 1, 0, 32'h52, 32'hDEAD_BEEF);
      #3;
      check("t4_mis_gnt0", bus.r0_gnt, 1);
      check("t4_mis_mem_we", bus.mem_we, 0);
      tick();
      check("t4_mis_rvalid", bus.r0_rvalid, 1);
      check("t4_mis_err", bus.r0_err, 1);
      check("t4_mis_rdata", bus.r0_rdata, 0);
      drv0(1, 1, 0, 32'h80, 32'hDEAD_BEEF);
      #3;
      check("t4_oor_mem_we", bus.mem_we, 0);
      tick();
      check("t4_oor_err", bus.r0_err, 1);
      check("t4_oor_rdata", bus.r0_rdata, 0);
      drv0(1, 0, 0, 32'h51, 0);
      tick();
      check("t4_misrd_err", bus.r0_err, 1);
      check("t4_misrd_rdata", bus.r0_rdata, 0);
      drv0(1, 0, 0, 32'h50, 0);
      tick();
      check("t4_word14", bus.r0_rdata, 32'hA3);
      check("t4_word14_err", bus.r0_err, 0);
      drv0(1, 0, 0, 32'h00, 0);
      tick();
      check("t4_word0", bus.r0_rdata, 32'h1000);

      // r1 write followed immediately by r0 read of the same word.
      drv0(0, 0, 0, 0, 0);
      drv1(1, 1, 0, 32'h60, 32'h258);
      #3;
      check("t5_gnt1", bus.r1_gnt, 1);
      check("t5_mem_we", bus.mem_we, 1);
      check("t5_mem_addr", bus.mem_addr, 32'h60);
      tick();
      check("t5_rvalid1", bus.r1_rvalid, 1);
      drv1(0, 0, 0, 0, 0);
      drv0(1, 0, 0, 32'h60, 0);
      #3;
      check("t5_gnt0", bus.r0_gnt, 1);
      tick();
      check("t5_rdata0", bus.r0_rdata, 32'h258);

      // Reset during an r1 lock: state must return to IDLE.
      drv0(0, 0, 0, 0, 0);
      drv1(1, 0, 1, 32'h64, 0);
      #3;
      check("t6a_gnt1", bus.r1_gnt, 1);
      tick();
      reset = 1'b1;
      drv0(1, 1, 0, 32'h70, 32'hBAD);
      drv1(1, 1, 1, 32'h64, 32'h123);
      #3;
      check("t6a_rst_gnt0", bus.r0_gnt, 0);
      check("t6a_rst_gnt1", bus.r1_gnt, 0);
      check("t6a_rst_mem_we", bus.mem_we, 0);
      tick();
      reset = 1'b0;
      check("t6a_rvalid0", bus.r0_rvalid, 0);
      check("t6a_rvalid1", bus.r1_rvalid, 0);
      drv0(1, 0, 0, 32'h68, 0);
      drv1(1, 0, 0, 32'h6C, 0);
      #3;
      check("t6a_first_gnt0", bus.r0_gnt, 1);
      check("t6a_first_gnt1", bus.r1_gnt, 0);
      tick();
      check("t6a_rdata0", bus.r0_rdata, 32'h101A);
      #3;
      check("t6a_next_gnt1", bus.r1_gnt, 1);
      tick();
      check("t6a_rdata1", bus.r1_rdata, 32'h101B);

      // Reset during an r0 lock: last must return to r1 so r0 wins again.
      drv1(0, 0, 0, 0, 0);
      drv0(1, 0, 1, 32'h68, 0);
      #3;
      check("t6b_gnt0", bus.r0_gnt, 1);
      tick();
      reset = 1'b1;
      drv1(1, 0, 0, 32'h6C, 0);
      #3;
      check("t6b_rst_gnt0", bus.r0_gnt, 0);
      check("t6b_rst_gnt1", bus.r1_gnt, 0);
      tick();
      reset = 1'b0;
      check("t6b_rvalid0", bus.r0_rvalid, 0);
      drv0(1, 0, 0, 32'h70, 0);
      #3;
      check("t6b_first_gnt0", bus.r0_gnt, 1);
      check("t6b_first_gnt1", bus.r1_gnt, 0);
      tick();
      check("t6b_dropped_wr", bus.r0_rdata, 32'h101C);

      drv0(0, 0, 0, 0, 0);
      drv1(0, 0, 0, 0, 0);
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
